// File: rtl/tlc_monitor_if.sv
// Lamp inputs and monitor status bundle between a traffic-light controller and its monitor.
// The lamp names follow the controller's own signal naming.
interface tlc_monitor_if;
  logic        Ga, Ya, Ra;
  logic        Gb, Yb, Rb;
  logic        clr_err;
  logic [1:0]  phase;
  logic        locked;
  logic        err_pulse;
  logic [2:0]  err_code;
  logic [7:0]  err_cnt;
  logic [15:0] cycle_cnt;

  modport master (
    output Ga, Ya, Ra, Gb, Yb, Rb, clr_err,
    input  phase, locked, err_pulse, err_code, err_cnt, cycle_cnt
  );

  modport slave (
    input  Ga, Ya, Ra, Gb, Yb, Rb, clr_err,
    output phase, locked, err_pulse, err_code, err_cnt, cycle_cnt
  );
endinterface

// File: rtl/tlc_monitor.sv
// Traffic-light sequence monitor: locks onto legal lamp patterns, tracks phase dwell
// times and reports illegal patterns, out-of-order phases and bad dwell lengths.
module tlc_monitor #(
  parameter int YEL_TICKS = 5,
  parameter int GRN_MIN   = 6
) (
  input  logic clk,
  input  logic reset,
  tlc_monitor_if.slave bus
);

  typedef enum logic {SYNC = 1'b0, TRACK = 1'b1} state_t;

  localparam logic [7:0] YEL_LEN = 8'(YEL_TICKS);
  localparam logic [7:0] GRN_LEN = 8'(GRN_MIN);

  state_t      state_reg, state_next;
  logic [1:0]  phase_reg, phase_next;
  logic        locked_reg, locked_next;
  logic        err_pulse_reg, err_pulse_next;
  logic [2:0]  err_code_reg, err_code_next;
  logic [7:0]  err_cnt_reg, err_cnt_next;
  logic [15:0] cycle_cnt_reg, cycle_cnt_next;
  logic [7:0]  dwell_reg, dwell_next;
  logic        partial_reg, partial_next;

  logic [5:0]  pattern;
  logic        legal;
  logic [1:0]  pat_phase;
  logic [2:0]  viol;
  logic [7:0]  cnt_base;
  logic [2:0]  code_base;

  assign pattern = {bus.Ga, bus.Ya, bus.Ra, bus.Gb, bus.Yb, bus.Rb};

  always_comb begin
    legal     = 1'b1;
    pat_phase = 2'd0;
    case (pattern)
      6'b100001: pat_phase = 2'd0;
      6'b010001: pat_phase = 2'd1;
      6'b001100: pat_phase = 2'd2;
      6'b001010: pat_phase = 2'd3;
      default:   legal     = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= SYNC;
      phase_reg     <= 2'd0;
      locked_reg    <= 1'b0;
      err_pulse_reg <= 1'b0;
      err_code_reg  <= 3'd0;
      err_cnt_reg   <= 8'd0;
      cycle_cnt_reg <= 16'd0;
      dwell_reg     <= 8'd0;
      partial_reg   <= 1'b1;
    end else begin
      state_reg     <= state_next;
      phase_reg     <= phase_next;
      locked_reg    <= locked_next;
      err_pulse_reg <= err_pulse_next;
      err_code_reg  <= err_code_next;
      err_cnt_reg   <= err_cnt_next;
      cycle_cnt_reg <= cycle_cnt_next;
      dwell_reg     <= dwell_next;
      partial_reg   <= partial_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    phase_next     = phase_reg;
    locked_next    = locked_reg;
    cycle_cnt_next = cycle_cnt_reg;
    dwell_next     = dwell_reg;
    partial_next   = partial_reg;
    viol           = 3'd0;

    case (state_reg)
      SYNC: begin
        if (legal) begin
          state_next   = TRACK;
          phase_next   = pat_phase;
          locked_next  = 1'b1;
          dwell_next   = 8'd1;
          partial_next = 1'b1;
        end
      end
      TRACK: begin
        if (!legal) begin
          viol        = 3'd1;
          locked_next = 1'b0;
          state_next  = SYNC;
        end else if (pat_phase == phase_reg) begin
          if (dwell_reg != 8'hFF) dwell_next = dwell_reg + 8'd1;
        end else if (pat_phase == phase_reg + 2'd1) begin
          // Dwell is only judged when the phase was observed from its start.
          if (!partial_reg) begin
            if (phase_reg[0] && dwell_reg != YEL_LEN)
              viol = 3'd3;
            else if (!phase_reg[0] && dwell_reg < GRN_LEN)
              viol = 3'd4;
          end
          if (phase_reg == 2'd3) cycle_cnt_next = cycle_cnt_reg + 16'd1;
          phase_next   = pat_phase;
          dwell_next   = 8'd1;
          partial_next = 1'b0;
        end else begin
          viol         = 3'd2;
          phase_next   = pat_phase;
          dwell_next   = 8'd1;
          partial_next = 1'b1;
        end
      end
      default: state_next = SYNC;
    endcase

    // A clear takes effect first so a same-cycle violation lands on a fresh count.
    code_base      = bus.clr_err ? 3'd0 : err_code_reg;
    cnt_base       = bus.clr_err ? 8'd0 : err_cnt_reg;
    err_pulse_next = (viol != 3'd0);
    err_code_next  = code_base;
    err_cnt_next   = cnt_base;
    if (viol != 3'd0) begin
      err_code_next = viol;
      if (cnt_base != 8'hFF) err_cnt_next = cnt_base + 8'd1;
    end
  end

  always_comb begin
    bus.phase     = phase_reg;
    bus.locked    = locked_reg;
    bus.err_pulse = err_pulse_reg;
    bus.err_code  = err_code_reg;
    bus.err_cnt   = err_cnt_reg;
    bus.cycle_cnt = cycle_cnt_reg;
  end

endmodule

// File: tb/tb_tlc_monitor.sv
// Randomised and directed bench for tlc_monitor, checked against a phase-level reference model.
module tb_tlc_monitor;

  localparam int YEL = 5;
  localparam int GRN = 6;

  localparam logic [5:0] P_AG  = 6'b100001;
  localparam logic [5:0] P_AY  = 6'b010001;
  localparam logic [5:0] P_BG  = 6'b001100;
  localparam logic [5:0] P_BY  = 6'b001010;
  localparam logic [5:0] P_BAD = 6'b101001;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  tlc_monitor_if bus();

  tlc_monitor #(.YEL_TICKS(YEL), .GRN_MIN(GRN)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;

  // reference model state
  int m_locked, m_phase, m_dwell, m_partial, m_code, m_cnt, m_cyc, m_pulse;
  logic [5:0] cur;
  logic [5:0] legal_pat [4];

  task automatic chk(input string tag, input logic [31:0] got, input int exp);
    tests++;
    if (got !== 32'(exp)) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int decode(input logic [5:0] p);
    for (int i = 0; i < 4; i++) if (legal_pat[i] == p) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_locked = 0; m_phase = 0; m_dwell = 0; m_partial = 1;
    m_code = 0; m_cnt = 0; m_cyc = 0; m_pulse = 0;
  endtask

  task automatic model_step(input logic [5:0] pat, input bit clr);
    int p, v;
    p = decode(pat);
    v = 0;
    if (m_locked == 0) begin
      if (p >= 0) begin
        m_phase = p; m_locked = 1; m_dwell = 1; m_partial = 1;
      end
    end else if (p < 0) begin
      v = 1; m_locked = 0;
    end else if (p == m_phase) begin
      m_dwell = (m_dwell >= 255) ? 255 : m_dwell + 1;
    end else if (p == (m_phase + 1) % 4) begin
      if (m_partial == 0) begin
        if ((m_phase % 2) == 1 && m_dwell != YEL) v = 3;
        else if ((m_phase % 2) == 0 && m_dwell < GRN) v = 4;
      end
      if (m_phase == 3) m_cyc = (m_cyc + 1) % 65536;
      m_phase = p; m_dwell = 1; m_partial = 0;
    end else begin
      v = 2; m_phase = p; m_dwell = 1; m_partial = 1;
    end
    if (clr) begin m_code = 0; m_cnt = 0; end
    m_pulse = (v != 0) ? 1 : 0;
    if (v != 0) begin
      m_code = v;
      m_cnt  = (m_cnt >= 255) ? 255 : m_cnt + 1;
    end
  endtask

  task automatic compare_all(input string tag);
    chk({tag, "_phase"},  bus.phase,     m_phase);
    chk({tag, "_locked"}, bus.locked,    m_locked);
    chk({tag, "_pulse"},  bus.err_pulse, m_pulse);
    chk({tag, "_code"},   bus.err_code,  m_code);
    chk({tag, "_cnt"},    bus.err_cnt,   m_cnt);
    chk({tag, "_cyc"},    bus.cycle_cnt, m_cyc);
  endtask

  // Called just after a rising edge; drives one sample and checks it one edge later.
  task automatic step(input logic [5:0] pat, input bit clr, input string tag);
    cur = pat;
    {bus.Ga, bus.Ya, bus.Ra, bus.Gb, bus.Yb, bus.Rb} = pat;
    bus.clr_err = clr;
    @(posedge clk);
    #1;
    model_step(pat, clr);
    compare_all(tag);
    $display("[TB] %s pat=%b clr=%0d phase=%0d locked=%0d code=%0d cnt=%0d cyc=%0d",
             tag, pat, clr, bus.phase, bus.locked, bus.err_code, bus.err_cnt, bus.cycle_cnt);
  endtask

  task automatic hold(input logic [5:0] pat, input int n, input string tag);
    for (int i = 0; i < n; i++) step(pat, 1'b0, tag);
  endtask

  // Asynchronous reset in the middle of a clock period; outputs must clear before the next edge.
  task automatic async_reset(input string tag);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    compare_all(tag);
    chk({tag, "_locked0"}, bus.locked, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    legal_pat[0] = P_AG; legal_pat[1] = P_AY; legal_pat[2] = P_BG; legal_pat[3] = P_BY;
    {bus.Ga, bus.Ya, bus.Ra, bus.Gb, bus.Yb, bus.Rb} = 6'b0;
    bus.clr_err = 1'b0;
    cur = P_AG;
    model_reset();

    #2 reset = 1'b1;
    #1 compare_all("rst");
    chk("rst_partial_cnt", bus.err_cnt, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // full legal cycle
    step(P_AG, 1'b0, "seq_first");
    chk("seq_locked_first", bus.locked, 1);
    hold(P_AG, 7, "seq_ag");
    hold(P_AY, 5, "seq_ay");
    hold(P_BG, 8, "seq_bg");
    hold(P_BY, 5, "seq_by");
    step(P_AG, 1'b0, "seq_end");
    chk("seq_cyc1", bus.cycle_cnt, 1);
    chk("seq_phase0", bus.phase, 0);
    chk("seq_cnt0", bus.err_cnt, 0);

    // short yellow
    hold(P_AG, 7, "y_ag");
    hold(P_AY, 4, "y_ay");
    step(P_BG, 1'b0, "y_bg");
    chk("y_pulse", bus.err_pulse, 1);
    chk("y_code3", bus.err_code, 3);
    chk("y_cnt1", bus.err_cnt, 1);
    step(P_BG, 1'b0, "y_bg2");
    chk("y_pulse_drop", bus.err_pulse, 0);

    // short green then an out-of-order jump
    hold(P_BG, 6, "g_bg");
    hold(P_BY, 5, "g_by");
    hold(P_AG, 3, "g_ag");
    step(P_AY, 1'b0, "g_ay");
    chk("g_code4", bus.err_code, 4);
    step(P_AG, 1'b0, "g_back");
    chk("g_code2", bus.err_code, 2);

    // illegal lamp combination then resync
    step(P_BAD, 1'b0, "ill");
    chk("ill_code1", bus.err_code, 1);
    chk("ill_unlock", bus.locked, 0);
    step(P_BG, 1'b0, "resync");
    chk("resync_locked", bus.locked, 1);
    chk("resync_pulse", bus.err_pulse, 0);
    chk("resync_phase", bus.phase, 2);

    // saturating error counter, then clear colliding with a violation
    for (int i = 0; i < 300; i++) step((i % 2 == 0) ? P_AG : P_BG, 1'b0, "sat");
    chk("sat_cnt", bus.err_cnt, 255);
    step(P_AG, 1'b1, "clr_viol");
    chk("clr_cnt1", bus.err_cnt, 1);
    chk("clr_code2", bus.err_code, 2);

    // async reset mid-yellow with a non-zero error count
    for (int i = 0; i < 6; i++) step((i % 2 == 0) ? P_BG : P_AG, 1'b0, "pre_rst");
    chk("pre_rst_cnt7", bus.err_cnt, 7);
    step(P_AY, 1'b0, "pre_rst_ay");
    step(P_AY, 1'b0, "pre_rst_ay");
    async_reset("arst");

    // randomised traffic
    for (int i = 0; i < 3000; i++) begin
      int r, p;
      logic [5:0] nxt;
      bit clr;
      r = $urandom_range(0, 99);
      p = decode(cur);
      if (r < 55) nxt = cur;
      else if (r < 80 && p >= 0) nxt = legal_pat[(p + 1) % 4];
      else if (r < 92) nxt = legal_pat[$urandom_range(0, 3)];
      else nxt = 6'($urandom_range(0, 63));
      clr = ($urandom_range(0, 19) == 0);
      step(nxt, clr, "rnd");
      if ($urandom_range(0, 399) == 0) async_reset("rnd_arst");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/tlc_monitor.md
TLC_MONITOR -- requirements
Module: tlc_monitor

Interface
REQ-001 Parameter YEL_TICKS, default 5: required yellow dwell in clock cycles (range 1-255).
REQ-002 Parameter GRN_MIN, default 6: minimum green dwell in clock cycles (range 1-255).
REQ-003 clk  input  1  system clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 Ga, Ya, Ra  input  1 each  road A green/yellow/red lamps, as driven by the TLC.
REQ-006 Gb, Yb, Rb  input  1 each  road B green/yellow/red lamps.
REQ-007 clr_err  input  1  synchronous clear of err_code and err_cnt.
REQ-008 phase  output  2  current tracked phase: 0=AG, 1=AY, 2=BG, 3=BY.
REQ-009 locked  output  1  high when the monitor is synchronised to a legal phase.
REQ-010 err_pulse  output  1  one-cycle strobe on a detected violation.
REQ-011 err_code  output  3  code of the most recent violation (0 = none).
REQ-012 err_cnt  output  8  violation count, saturating.
REQ-013 cycle_cnt  output  16  completed signal cycles, wrapping.

Function
REQ-014 Legal lamp patterns {Ga,Ya,Ra,Gb,Yb,Rb}: AG=100001, AY=010001, BG=001100, BY=001010; every other value is ILLEGAL.
REQ-015 The monitor samples the inputs every rising edge; all outputs are registered and reflect the sample taken at that same edge (one-cycle latency).
REQ-016 FSM states: SYNC, TRACK.
REQ-017 In SYNC, a legal pattern loads phase, sets locked=1, sets dwell=1, sets partial=1, moves to TRACK, and flags nothing.
REQ-018 In SYNC, an ILLEGAL pattern keeps SYNC with no error flagged.
REQ-019 In TRACK, an ILLEGAL pattern flags code 1, clears locked, and moves to SYNC.
REQ-020 In TRACK, an unchanged pattern increments dwell, saturating at 255.
REQ-021 Legal successor transitions: AG->AY, AY->BG, BG->BY, BY->AG; any other change between legal patterns flags code 2 and loads the new phase, with dwell=1 and partial=1.
REQ-022 On leaving AY or BY legally with partial=0, dwell != YEL_TICKS flags code 3.
REQ-023 On leaving AG or BG legally with partial=0, dwell < GRN_MIN flags code 4.
REQ-024 Every legal transition loads the new phase, sets dwell=1, and clears partial.
REQ-025 A legal BY->AG transition increments cycle_cnt, wrapping 65535->0.
REQ-026 Priority: code 1 > 2 > 3 > 4; at most one violation is flagged per cycle.
REQ-027 A flagged violation asserts err_pulse for exactly that cycle, writes err_code, and increments err_cnt, saturating at 255.
REQ-028 When clr_err=1, err_code and err_cnt clear to 0; a violation in the same cycle is applied after the clear, giving err_code=new code and err_cnt=1.
REQ-029 clr_err affects neither phase, locked, nor cycle_cnt.

Reset
REQ-030 While reset=1, all outputs are forced immediately, regardless of clk, to: state=SYNC, phase=0, locked=0, err_pulse=0, err_code=0, err_cnt=0, cycle_cnt=0, dwell=0, partial=1.
REQ-031 After reset deasserts, the first legal sample is handled per REQ-017; a reset asserted mid-phase discards all dwell history.

Verification
REQ-032 Reset, then AG x8, AY x5, BG x8, BY x5, AG -> no err_pulse, locked=1 from the 1st sample, cycle_cnt=1 at the final AG sample, phase=0.
REQ-033 Locked and legal sequence with AY held 4 cycles, then BG -> err_pulse=1 for 1 cycle, err_code=3, err_cnt=1.
REQ-034 Locked, AG held 3 cycles after a legal entry, then AY -> err_code=4; next, AY->AG -> err_code=2, with no code-3 check on that exit.
REQ-035 In TRACK, drive 101001 (Ga and Ra both on) -> err_code=1, locked=0 next cycle; then BG -> locked=1, no error, phase=2.
REQ-036 Force 300 violations -> err_cnt holds at 255; assert clr_err in the same cycle as a violation -> err_cnt=1, err_code=that violation's code.
REQ-037 Assert reset asynchronously mid-AY with err_cnt=7 -> all outputs are 0 before the next clk edge, and locked=0.
